counter_sequencer: RTL and testbench
====================================

Name: counter_sequencer

Overview:
- Control block for the board counter datapath; sits between the KEY push buttons / SW switches and the BCD/7-segment display chain.
- Debounces and edge-detects three active-low keys and turns them into load, single-step and run/pause commands.
- Holds the count register and, in RUN, advances it on a prescaled tick.
- Supports a programmable modulus and a count direction; drives `count` to the `binary_to_BCD` input.

Parameters:
- WIDTH, 8, count width (matches the 8-bit BCD converter input).
- DEBOUNCE_CYCLES, 16, consecutive stable synchronized samples needed to accept a key level (1_000_000 on board).
- TICK_DIV, 50_000_000, CLOCK_50 cycles per auto-count tick in RUN (1 Hz on board); must be ≥2.

Ports:
- CLOCK_50  input  1  system clock, all logic on rising edge
- reset  input  1  synchronous, active-high reset
- key_load_n  input  1  raw push button, low = pressed; load command
- key_step_n  input  1  raw push button, low = pressed; single-step command
- key_run_n  input  1  raw push button, low = pressed; run/pause toggle
- load_value  input  WIDTH  value loaded on load command (from SW)
- modulus  input  WIDTH  count range 0..modulus-1; 0 means full 2^WIDTH range
- dir  input  1  0 = count up, 1 = count down; sampled at each advance
- count  output  WIDTH  current count, registered
- state  output  2  00 IDLE, 01 RUN, 10 PAUSE (11 never driven)
- tick  output  1  one-cycle pulse when the prescaler expires in RUN
- wrap  output  1  one-cycle pulse on the cycle count wraps

Behaviour:
- Interface (already decided): one clock, CLOCK_50; `reset` is synchronous and active-high.
- Reset, synchronous, highest priority over everything:
  - count=0, state=IDLE, tick=0, wrap=0, prescaler=0.
  - Synchronizers and debounced levels = 1 (released); debounce counters = 0.
  - Reset mid-RUN aborts immediately; no wrap/tick pulse is emitted.
- Key conditioning, per key:
  - 2-flop synchronizer.
  - Debounce counter: cleared whenever synchronized value == debounced level; otherwise incremented.
  - On reaching DEBOUNCE_CYCLES-1 the debounced level takes the synchronized value and the counter clears.
  - Press event = debounced level 1→0, exactly one cycle wide; release produces no event.
  - Glitches shorter than DEBOUNCE_CYCLES produce no event.
- Command priority when events coincide: load > run > step; the lower-priority events that cycle are dropped.
- FSM:
  - IDLE + run → RUN; RUN + run → PAUSE; PAUSE + run → RUN.
  - Load in any state → IDLE.
  - Step: acted on in IDLE and PAUSE; ignored in RUN.
  - Entry into RUN clears the prescaler.
- Load:
  - count ← load_value when modulus==0 or load_value<modulus.
  - Otherwise count ← modulus-1 (clamp).
  - Load never pulses wrap.
- Advance (step event, or tick in RUN):
  - Up: count==last → 0, with wrap=1 for one cycle; else count+1. last = modulus-1, or 2^WIDTH-1 when modulus==0.
  - Down: count==0 → last, with wrap=1; else count-1.
  - count above last (modulus lowered at runtime): next advance forces 0 and pulses wrap.
- Prescaler (RUN only):
  - Counts 0..TICK_DIV-1; at TICK_DIV-1 it asserts tick for one cycle and returns to 0.
  - The advance is visible on count the cycle after tick.
  - Holds its value in PAUSE; cleared in IDLE.
- Latency:
  - Key press to event: 2 synchronizer cycles + DEBOUNCE_CYCLES.
  - Event to count/state update: 1 cycle.
- Outputs are registered; no combinational path from inputs to outputs.

Test Plan (DEBOUNCE_CYCLES=4, TICK_DIV=5, WIDTH=8):
- Reset, then hold key_load_n low with load_value=37, modulus=0 → count=37, state=00; one load event only while the key is held.
- modulus=10, load 9, dir=0, one step press → count=0 with a single wrap pulse; set dir=1, step → count=9 with wrap; 2-cycle glitches on key_step_n → no change.
- Run press from IDLE with count=0 → state=01; tick every 5 cycles; count 1,2,3 after three ticks. Run press → state=10, count frozen. Run again → resumes without losing the partial prescale.
- In RUN, step presses → ignored. Load and run debounced on the same cycle → load wins: count=load_value, state=00.
- load_value=200, modulus=100 → count=99. Lower modulus to 50, step up → count=0, wrap=1.
- Assert reset mid-RUN at count=4 → next cycle count=0, state=00, tick=0, wrap=0; no spurious event after reset deasserts while keys are still held released.

Source files
------------

// File: rtl/counter_sequencer_if.sv
// -----------------------------------------------------------------------------
// counter_sequencer_if
//
// Purpose:
//   Bundles the board-facing key/switch inputs and the counter outputs of the
//   counter sequencer. The clock and reset stay plain module ports.
//
// Signals:
//   key_load_n  raw push button, low = pressed, load command
//   key_step_n  raw push button, low = pressed, single-step command
//   key_run_n   raw push button, low = pressed, run/pause toggle
//   load_value  value loaded on a load command (from SW)
//   modulus     count range 0..modulus-1, 0 selects the full 2^WIDTH range
//   dir         0 = count up, 1 = count down
//   count       current count (registered)
//   state       00 IDLE, 01 RUN, 10 PAUSE
//   tick        one-cycle pulse when the prescaler expires in RUN
//   wrap        one-cycle pulse on the cycle the count wraps
//
// Modports:
//   master  board / testbench side: drives keys and switches, observes outputs
//   slave   the sequencer itself
// -----------------------------------------------------------------------------
interface counter_sequencer_if #(
  parameter int WIDTH = 8
);

  logic             key_load_n;
  logic             key_step_n;
  logic             key_run_n;
  logic [WIDTH-1:0] load_value;
  logic [WIDTH-1:0] modulus;
  logic             dir;
  logic [WIDTH-1:0] count;
  logic [1:0]       state;
  logic             tick;
  logic             wrap;

  modport master (
    output key_load_n,
    output key_step_n,
    output key_run_n,
    output load_value,
    output modulus,
    output dir,
    input  count,
    input  state,
    input  tick,
    input  wrap
  );

  modport slave (
    input  key_load_n,
    input  key_step_n,
    input  key_run_n,
    input  load_value,
    input  modulus,
    input  dir,
    output count,
    output state,
    output tick,
    output wrap
  );

endinterface

// File: rtl/counter_sequencer.sv
// -----------------------------------------------------------------------------
// counter_sequencer
//
// Purpose:
//   Control block for the board counter datapath. Conditions three active-low
//   push buttons (synchronise, debounce, press-edge detect), turns them into
//   load / single-step / run-pause commands, and owns the count register that
//   feeds the binary_to_BCD converter. In RUN the count advances on a tick
//   produced by a prescaler; the modulus and direction are programmable.
//
// Parameters:
//   WIDTH            count width
//   DEBOUNCE_CYCLES  consecutive stable synchronised samples to accept a level
//   TICK_DIV         clock cycles per auto-count tick in RUN (>= 2)
//
// Ports:
//   CLOCK_50  system clock, everything on the rising edge
//   reset     synchronous, active-high reset
//   bus       counter_sequencer_if.slave: keys, load_value, modulus, dir in;
//             count, state, tick, wrap out (all outputs registered)
// -----------------------------------------------------------------------------
module counter_sequencer #(
  parameter int WIDTH           = 8,
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int TICK_DIV        = 50_000_000
) (
  input logic                CLOCK_50,
  input logic                reset,
  counter_sequencer_if.slave bus
);

  // Key indices into the conditioning vectors
  localparam int KEY_LOAD = 0;
  localparam int KEY_STEP = 1;
  localparam int KEY_RUN  = 2;

  // The debounce counter only ever needs to reach DEBOUNCE_CYCLES-1
  localparam int DCW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int PCW = $clog2(TICK_DIV);

  localparam logic [DCW-1:0] DEB_LAST   = DCW'(DEBOUNCE_CYCLES - 1);
  localparam logic [PCW-1:0] PRESC_LAST = PCW'(TICK_DIV - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    RUN   = 2'b01,
    PAUSE = 2'b10
  } state_e;

  logic [2:0]          keyRaw;
  logic [2:0]          keySync1_q;
  logic [2:0]          keySync2_q;
  logic [2:0]          keyDeb_q;
  logic [2:0]          keyDeb_d;
  logic [2:0][DCW-1:0] debCnt_q;
  logic [2:0][DCW-1:0] debCnt_d;
  logic [2:0]          keyEvt_q;
  logic [2:0]          keyEvt_d;

  logic                loadCmd;
  logic                runCmd;
  logic                stepCmd;

  state_e              state_q;
  state_e              state_d;
  logic [PCW-1:0]      presc_q;
  logic [PCW-1:0]      presc_d;
  logic                tick_q;
  logic                tick_d;
  logic [WIDTH-1:0]    count_q;
  logic [WIDTH-1:0]    count_d;
  logic                wrap_q;
  logic                wrap_d;

  logic [WIDTH-1:0]    lastVal;
  logic [WIDTH-1:0]    loadClamped;
  logic                advance;

  assign keyRaw = {bus.key_run_n, bus.key_step_n, bus.key_load_n};

  // Two-flop synchronisers, debounced levels and press-event flags for all
  // three keys. Everything idles at "released" so leaving reset with the keys
  // up never looks like a press.
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      keySync1_q <= 3'b111;
      keySync2_q <= 3'b111;
      keyDeb_q   <= 3'b111;
      debCnt_q   <= '0;
      keyEvt_q   <= 3'b000;
    end else begin
      keySync1_q <= keyRaw;
      keySync2_q <= keySync1_q;
      keyDeb_q   <= keyDeb_d;
      debCnt_q   <= debCnt_d;
      keyEvt_q   <= keyEvt_d;
    end
  end

  // Debounce: any sample that agrees with the accepted level restarts the
  // count, so only an unbroken run of DEBOUNCE_CYCLES disagreeing samples
  // flips the level. Short glitches therefore vanish without an event.
  always_comb begin
    keyDeb_d = keyDeb_q;
    debCnt_d = debCnt_q;
    for (int i = 0; i < 3; i++) begin
      if (keySync2_q[i] == keyDeb_q[i]) begin
        debCnt_d[i] = '0;
      end else if (debCnt_q[i] == DEB_LAST) begin
        keyDeb_d[i] = keySync2_q[i];
        debCnt_d[i] = '0;
      end else begin
        debCnt_d[i] = debCnt_q[i] + DCW'(1);
      end
    end
  end

  // A press is the accepted level going 1 -> 0; releases are not events.
  assign keyEvt_d = keyDeb_q & ~keyDeb_d;

  // Coincident events resolve as load > run > step; the losers are dropped.
  assign loadCmd = keyEvt_q[KEY_LOAD];
  assign runCmd  = keyEvt_q[KEY_RUN] & ~loadCmd;
  assign stepCmd = keyEvt_q[KEY_STEP] & ~loadCmd & ~keyEvt_q[KEY_RUN];

  // Control state, prescaler and count registers with their pulse outputs.
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      state_q <= IDLE;
      presc_q <= '0;
      tick_q  <= 1'b0;
      count_q <= '0;
      wrap_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      presc_q <= presc_d;
      tick_q  <= tick_d;
      count_q <= count_d;
      wrap_q  <= wrap_d;
    end
  end

  // Run/pause FSM. Load forces IDLE from anywhere; the run key toggles
  // between RUN and PAUSE once started from IDLE.
  always_comb begin
    state_d = state_q;
    if (loadCmd) begin
      state_d = IDLE;
    end else if (runCmd) begin
      case (state_q)
        IDLE:    state_d = RUN;
        RUN:     state_d = PAUSE;
        PAUSE:   state_d = RUN;
        default: state_d = IDLE;
      endcase
    end
  end

  // Prescaler. It only counts while the FSM stays in RUN, so the cycle that
  // enters PAUSE already freezes it and a later resume continues from the
  // partial value. IDLE (and any start from IDLE) begins from zero.
  always_comb begin
    presc_d = presc_q;
    tick_d  = 1'b0;
    if (state_d == IDLE || state_q == IDLE) begin
      presc_d = '0;
    end else if (state_q == RUN && state_d == RUN) begin
      if (presc_q == PRESC_LAST) begin
        presc_d = '0;
        tick_d  = 1'b1;
      end else begin
        presc_d = presc_q + PCW'(1);
      end
    end
  end

  // Top of the counting range; a modulus of zero means the full width.
  assign lastVal = (bus.modulus == '0) ? '1 : bus.modulus - WIDTH'(1);

  // Loaded values outside the range are clamped to the top of the range.
  assign loadClamped = (bus.modulus == '0 || bus.load_value < bus.modulus)
                       ? bus.load_value : lastVal;

  // tick_q can only be high after a RUN -> RUN cycle, so it alone marks an
  // auto advance; steps are honoured everywhere except RUN.
  assign advance = tick_q | (stepCmd & (state_q != RUN));

  // Count update. A count left above the range by a runtime modulus change
  // is pulled back to zero (with a wrap) on the next advance in either
  // direction.
  always_comb begin
    count_d = count_q;
    wrap_d  = 1'b0;
    if (loadCmd) begin
      count_d = loadClamped;
    end else if (advance) begin
      if (!bus.dir) begin
        if (count_q >= lastVal) begin
          count_d = '0;
          wrap_d  = 1'b1;
        end else begin
          count_d = count_q + WIDTH'(1);
        end
      end else begin
        if (count_q == '0) begin
          count_d = lastVal;
          wrap_d  = 1'b1;
        end else if (count_q > lastVal) begin
          count_d = '0;
          wrap_d  = 1'b1;
        end else begin
          count_d = count_q - WIDTH'(1);
        end
      end
    end
  end

  assign bus.count = count_q;
  assign bus.state = state_q;
  assign bus.tick  = tick_q;
  assign bus.wrap  = wrap_q;

endmodule

// File: tb/tb_counter_sequencer.sv
// -----------------------------------------------------------------------------
// tb_counter_sequencer
//
// Purpose:
//   Self-checking bench for counter_sequencer with DEBOUNCE_CYCLES=4,
//   TICK_DIV=5, WIDTH=8. Auto-count values are predicted into a queue before
//   RUN is entered and popped by a monitor on the cycle after each tick.
// -----------------------------------------------------------------------------
module tb_counter_sequencer;

  localparam int WIDTH = 8;
  localparam int KLOAD = 0;
  localparam int KSTEP = 1;
  localparam int KRUN  = 2;

  logic             CLOCK_50 = 1'b0;
  logic             reset;
  int               checkCount = 0;
  int               passCount  = 0;
  int               tickSeen   = 0;
  int               wrapSeen   = 0;
  logic             tickPrev   = 1'b0;
  logic [WIDTH-1:0] expCount;
  logic [WIDTH-1:0] expQ [$];

  counter_sequencer_if #(.WIDTH(WIDTH)) bus ();

  counter_sequencer #(
    .WIDTH(WIDTH),
    .DEBOUNCE_CYCLES(4),
    .TICK_DIV(5)
  ) dut (
    .CLOCK_50(CLOCK_50),
    .reset(reset),
    .bus(bus)
  );

  // 100 MHz-style free-running clock
  always #5 CLOCK_50 = ~CLOCK_50;

  // Pulse counters plus the scoreboard: the cycle after a tick the count must
  // equal the oldest predicted value.
  always @(negedge CLOCK_50) begin
    if (bus.tick === 1'b1) tickSeen++;
    if (bus.wrap === 1'b1) wrapSeen++;
    if (tickPrev === 1'b1 && expQ.size() > 0) begin
      expCount = expQ.pop_front();
      checkCount++;
      if (bus.count !== expCount)
        $display("[TB] FAIL sb_tick_count: count=%0d expected=%0d", bus.count, expCount);
      else
        passCount++;
    end
    tickPrev = bus.tick;
  end

  // Safety net against a hung run
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, passed=%0d checks=%0d", passCount, checkCount);
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic setKey(input int k, input logic v);
    case (k)
      KLOAD:   bus.key_load_n = v;
      KSTEP:   bus.key_step_n = v;
      default: bus.key_run_n  = v;
    endcase
  endtask

  // Full press: held long enough to register, then released and settled.
  task automatic pressKey(input int k);
    setKey(k, 1'b0);
    repeat (8) @(negedge CLOCK_50);
    setKey(k, 1'b1);
    repeat (8) @(negedge CLOCK_50);
  endtask

  task automatic test_reset();
    int w;
    int t;
    reset = 1'b1;
    bus.key_load_n = 1'b1;
    bus.key_step_n = 1'b1;
    bus.key_run_n  = 1'b1;
    bus.load_value = '0;
    bus.modulus    = '0;
    bus.dir        = 1'b0;
    repeat (3) @(negedge CLOCK_50);
    checkCount++;
    if (bus.count !== 8'd0 || bus.state !== 2'b00 || bus.tick !== 1'b0 || bus.wrap !== 1'b0)
      $display("[TB] FAIL reset_values: count=%0d state=%b tick=%b wrap=%b expected 0/00/0/0",
               bus.count, bus.state, bus.tick, bus.wrap);
    else passCount++;
    reset = 1'b0;
    w = wrapSeen;
    t = tickSeen;
    repeat (20) @(negedge CLOCK_50);
    checkCount++;
    if (bus.count !== 8'd0 || bus.state !== 2'b00 || wrapSeen != w || tickSeen != t)
      $display("[TB] FAIL reset_idle: count=%0d state=%b expected 0/00 with no pulses", bus.count, bus.state);
    else passCount++;
  endtask

  task automatic test_load_hold();
    int w;
    w = wrapSeen;
    bus.load_value = 8'd37;
    bus.modulus    = 8'd0;
    bus.key_load_n = 1'b0;
    repeat (6) @(negedge CLOCK_50);
    checkCount++;
    if (bus.count !== 8'd0)
      $display("[TB] FAIL load_latency_early: count=%0d expected=0", bus.count);
    else passCount++;
    @(negedge CLOCK_50);
    checkCount++;
    if (bus.count !== 8'd37 || bus.state !== 2'b00)
      $display("[TB] FAIL load_value: count=%0d state=%b expected 37/00", bus.count, bus.state);
    else passCount++;
    bus.load_value = 8'd55;
    repeat (20) @(negedge CLOCK_50);
    checkCount++;
    if (bus.count !== 8'd37 || wrapSeen != w)
      $display("[TB] FAIL load_single_event: count=%0d wraps=%0d expected 37 and 0 wraps", bus.count, wrapSeen - w);
    else passCount++;
    bus.key_load_n = 1'b1;
    repeat (8) @(negedge CLOCK_50);
  endtask

  task automatic test_step();
    int w;
    bus.modulus    = 8'd10;
    bus.load_value = 8'd9;
    pressKey(KLOAD);
    checkCount++;
    if (bus.count !== 8'd9)
      $display("[TB] FAIL step_preload: count=%0d expected=9", bus.count);
    else passCount++;
    bus.dir = 1'b0;
    w = wrapSeen;
    pressKey(KSTEP);
    checkCount++;
    if (bus.count !== 8'd0 || wrapSeen - w != 1)
      $display("[TB] FAIL step_up_wrap: count=%0d wraps=%0d expected 0 and 1", bus.count, wrapSeen - w);
    else passCount++;
    bus.dir = 1'b1;
    w = wrapSeen;
    pressKey(KSTEP);
    checkCount++;
    if (bus.count !== 8'd9 || wrapSeen - w != 1)
      $display("[TB] FAIL step_down_wrap: count=%0d wraps=%0d expected 9 and 1", bus.count, wrapSeen - w);
    else passCount++;
    w = wrapSeen;
    pressKey(KSTEP);
    checkCount++;
    if (bus.count !== 8'd8 || wrapSeen != w)
      $display("[TB] FAIL step_down_plain: count=%0d wraps=%0d expected 8 and 0", bus.count, wrapSeen - w);
    else passCount++;
  endtask

  task automatic test_glitch();
    int w;
    w = wrapSeen;
    for (int g = 0; g < 3; g++) begin
      bus.key_step_n = 1'b0;
      repeat (2) @(negedge CLOCK_50);
      bus.key_step_n = 1'b1;
      repeat (6) @(negedge CLOCK_50);
    end
    repeat (10) @(negedge CLOCK_50);
    checkCount++;
    if (bus.count !== 8'd8 || bus.state !== 2'b00 || wrapSeen != w)
      $display("[TB] FAIL glitch_ignored: count=%0d state=%b expected 8/00", bus.count, bus.state);
    else passCount++;
  endtask

  task automatic test_run();
    int n;
    int t;
    bus.dir        = 1'b0;
    bus.load_value = 8'd0;
    pressKey(KLOAD);
    expQ.push_back(8'd1);
    expQ.push_back(8'd2);
    expQ.push_back(8'd3);
    bus.key_run_n = 1'b0;
    n = 0;
    while (bus.state !== 2'b01 && n < 20) begin @(negedge CLOCK_50); n++; end
    bus.key_run_n = 1'b1;
    checkCount++;
    if (n != 7 || bus.state !== 2'b01)
      $display("[TB] FAIL run_entry: cycles=%0d state=%b expected 7 cycles to 01", n, bus.state);
    else passCount++;
    for (int k = 0; k < 3; k++) begin
      n = 0;
      @(negedge CLOCK_50); n++;
      while (bus.tick !== 1'b1 && n < 20) begin @(negedge CLOCK_50); n++; end
      checkCount++;
      if (n != 5)
        $display("[TB] FAIL tick_period: cycles=%0d expected=5", n);
      else passCount++;
    end
    // Pause right at the third tick; the fourth tick still lands before PAUSE
    expQ.push_back(8'd4);
    bus.key_run_n = 1'b0;
    n = 0;
    while (bus.state !== 2'b10 && n < 20) begin @(negedge CLOCK_50); n++; end
    bus.key_run_n = 1'b1;
    checkCount++;
    if (n != 7 || bus.count !== 8'd4)
      $display("[TB] FAIL pause_entry: cycles=%0d count=%0d expected 7 and 4", n, bus.count);
    else passCount++;
    t = tickSeen;
    repeat (12) @(negedge CLOCK_50);
    checkCount++;
    if (bus.count !== 8'd4 || bus.state !== 2'b10 || tickSeen != t || expQ.size() != 0)
      $display("[TB] FAIL pause_frozen: count=%0d state=%b ticks=%0d pending=%0d expected 4/10/0/0",
               bus.count, bus.state, tickSeen - t, expQ.size());
    else passCount++;
    // Resume: prescaler held 1 at pause, so the next tick is 4 cycles away
    expQ.push_back(8'd5);
    bus.key_run_n = 1'b0;
    n = 0;
    while (bus.state !== 2'b01 && n < 20) begin @(negedge CLOCK_50); n++; end
    bus.key_run_n = 1'b1;
    n = 0;
    @(negedge CLOCK_50); n++;
    while (bus.tick !== 1'b1 && n < 20) begin @(negedge CLOCK_50); n++; end
    checkCount++;
    if (n != 4)
      $display("[TB] FAIL resume_partial_prescale: cycles=%0d expected=4", n);
    else passCount++;
    @(negedge CLOCK_50);
  endtask

  task automatic test_run_ignores_step();
    int n;
    expQ.push_back(8'd6);
    expQ.push_back(8'd7);
    expQ.push_back(8'd8);
    expQ.push_back(8'd9);
    pressKey(KSTEP);
    n = 0;
    while (expQ.size() != 0 && n < 40) begin @(negedge CLOCK_50); n++; end
    checkCount++;
    if (expQ.size() != 0 || bus.state !== 2'b01)
      $display("[TB] FAIL run_step_ignored: pending=%0d state=%b expected 0 and 01", expQ.size(), bus.state);
    else passCount++;
  endtask

  task automatic test_load_beats_run();
    bus.load_value = 8'd7;
    bus.key_load_n = 1'b0;
    bus.key_run_n  = 1'b0;
    repeat (8) @(negedge CLOCK_50);
    checkCount++;
    if (bus.count !== 8'd7 || bus.state !== 2'b00)
      $display("[TB] FAIL load_priority: count=%0d state=%b expected 7/00", bus.count, bus.state);
    else passCount++;
    bus.key_load_n = 1'b1;
    bus.key_run_n  = 1'b1;
    repeat (10) @(negedge CLOCK_50);
    checkCount++;
    if (bus.count !== 8'd7 || bus.state !== 2'b00)
      $display("[TB] FAIL load_priority_hold: count=%0d state=%b expected 7/00", bus.count, bus.state);
    else passCount++;
  endtask

  task automatic test_clamp_and_modulus();
    int w;
    bus.load_value = 8'd200;
    bus.modulus    = 8'd100;
    pressKey(KLOAD);
    checkCount++;
    if (bus.count !== 8'd99)
      $display("[TB] FAIL load_clamp: count=%0d expected=99", bus.count);
    else passCount++;
    bus.modulus = 8'd50;
    bus.dir     = 1'b0;
    w = wrapSeen;
    pressKey(KSTEP);
    checkCount++;
    if (bus.count !== 8'd0 || wrapSeen - w != 1)
      $display("[TB] FAIL above_range_step: count=%0d wraps=%0d expected 0 and 1", bus.count, wrapSeen - w);
    else passCount++;
  endtask

  task automatic test_reset_mid_run();
    int n;
    int w;
    int t;
    bus.modulus    = 8'd0;
    bus.load_value = 8'd0;
    pressKey(KLOAD);
    for (int v = 1; v <= 4; v++) expQ.push_back(WIDTH'(v));
    bus.key_run_n = 1'b0;
    n = 0;
    while (bus.state !== 2'b01 && n < 20) begin @(negedge CLOCK_50); n++; end
    bus.key_run_n = 1'b1;
    n = 0;
    while (bus.count !== 8'd4 && n < 60) begin @(negedge CLOCK_50); n++; end
    checkCount++;
    if (bus.count !== 8'd4 || bus.state !== 2'b01)
      $display("[TB] FAIL reach_count4: count=%0d state=%b expected 4/01", bus.count, bus.state);
    else passCount++;
    reset = 1'b1;
    @(negedge CLOCK_50);
    checkCount++;
    if (bus.count !== 8'd0 || bus.state !== 2'b00 || bus.tick !== 1'b0 || bus.wrap !== 1'b0)
      $display("[TB] FAIL reset_mid_run: count=%0d state=%b tick=%b wrap=%b expected 0/00/0/0",
               bus.count, bus.state, bus.tick, bus.wrap);
    else passCount++;
    expQ.delete();
    @(negedge CLOCK_50);
    reset = 1'b0;
    w = wrapSeen;
    t = tickSeen;
    repeat (20) @(negedge CLOCK_50);
    checkCount++;
    if (bus.count !== 8'd0 || bus.state !== 2'b00 || wrapSeen != w || tickSeen != t)
      $display("[TB] FAIL post_reset_quiet: count=%0d state=%b ticks=%0d wraps=%0d expected 0/00/0/0",
               bus.count, bus.state, tickSeen - t, wrapSeen - w);
    else passCount++;
  endtask

  // Scenario sequence
  initial begin
    test_reset();
    test_load_hold();
    test_step();
    test_glitch();
    test_run();
    test_run_ignores_step();
    test_load_beats_run();
    test_clamp_and_modulus();
    test_reset_mid_run();
    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
